// File: rtl/kim_hazard_ctrl_p.sv
// kim_hazard_ctrl_p: hazard, flush, forwarding and MDU sequencing control
// for a 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
//
// Ports:
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   id_rs, id_rt        source indices of the instruction in ID
//   id_mdu_req          ID holds mult/multu/div/divu
//   id_mdu_read         ID holds mfhi/mflo
//   ex_rt, ex_rd_dst    EX rt index and destination index
//   ex_reg_write        EX writes the register file
//   ex_mem_read         EX is a load
//   ex_branch_taken     branch/jump resolved taken in EX
//   mem_rd_dst          MEM destination index
//   mem_reg_write       MEM writes the register file
//   stall_pc/stall_ifid hold PC and IF/ID
//   bubble_idex         load a NOP into ID/EX
//   flush_ifid          clear IF/ID
//   fwd_a/fwd_b         00 regfile, 01 MEM/WB, 10 EX/MEM
//   mdu_start           one-cycle MDU start pulse
//   mdu_busy            MDU operation in progress
//   mdu_done            registered pulse when the MDU result is valid
//
// Build option: define KIM_FWD_EN to enable operand forwarding. Without it,
// forwarding selects stay 00 and RAW dependences on EX/MEM stall instead.
module kim_hazard_ctrl_p #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MDU_LATENCY    = 32,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt,
    input  logic                      id_mdu_req,
    input  logic                      id_mdu_read,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rt,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_dst,
    input  logic                      ex_reg_write,
    input  logic                      ex_mem_read,
    input  logic                      ex_branch_taken,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd_dst,
    input  logic                      mem_reg_write,
    output logic                      stall_pc,
    output logic                      stall_ifid,
    output logic                      bubble_idex,
    output logic                      flush_ifid,
    output logic [1:0]                fwd_a,
    output logic [1:0]                fwd_b,
    output logic                      mdu_start,
    output logic                      mdu_busy,
    output logic                      mdu_done
);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   done_q, done_d;

    logic                   busy;
    logic                   hz_lu;
    logic                   hz_mdu;
    logic                   hz_raw;
    logic                   any_stall;
    logic                   start_ok;
    logic [1:0]             fwd_a_raw;
    logic [1:0]             fwd_b_raw;

    // Register 0 is hardwired, so it never matches a producer.
    function automatic logic hit(
        input logic [REG_ADDR_WIDTH-1:0] dst,
        input logic [REG_ADDR_WIDTH-1:0] src
    );
        return (dst != '0) && (dst == src);
    endfunction

`ifdef KIM_FWD_EN
    // EX/MEM is the younger producer, so it wins over MEM/WB.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_WIDTH-1:0] src
    );
        if (ex_reg_write && hit(ex_rd_dst, src))
            return 2'b10;
        else if (mem_reg_write && hit(mem_rd_dst, src))
            return 2'b01;
        else
            return 2'b00;
    endfunction
`else
    function automatic logic live_dep(
        input logic [REG_ADDR_WIDTH-1:0] src
    );
        return (ex_reg_write && hit(ex_rd_dst, src)) ||
               (mem_reg_write && hit(mem_rd_dst, src));
    endfunction
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Hazard detection
    always_comb begin
        busy   = (state_q == S_BUSY);
        hz_lu  = ex_mem_read && (hit(ex_rt, id_rs) || hit(ex_rt, id_rt));
        hz_mdu = busy && (id_mdu_read || id_mdu_req);
`ifdef KIM_FWD_EN
        hz_raw    = 1'b0;
        fwd_a_raw = fwd_sel(id_rs);
        fwd_b_raw = fwd_sel(id_rt);
`else
        hz_raw    = live_dep(id_rs) || live_dep(id_rt);
        fwd_a_raw = 2'b00;
        fwd_b_raw = 2'b00;
`endif
        any_stall = hz_lu || hz_mdu || hz_raw;
        // Start only when the mult really leaves ID this cycle.
        start_ok  = !busy && id_mdu_req && !any_stall && !ex_branch_taken;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_BUSY;
                    cnt_d   = CNT_WIDTH'(MDU_LATENCY - 1);
                end
            end
            S_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs, all forced low while reset is held
    always_comb begin
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        bubble_idex = 1'b0;
        flush_ifid  = 1'b0;
        fwd_a       = 2'b00;
        fwd_b       = 2'b00;
        mdu_start   = 1'b0;
        mdu_busy    = 1'b0;
        mdu_done    = 1'b0;
        if (rst_n) begin
            // A taken branch makes the ID instruction wrong-path,
            // so it overrides any stall.
            priority case (1'b1)
                ex_branch_taken: begin
                    flush_ifid  = 1'b1;
                    bubble_idex = 1'b1;
                end
                any_stall: begin
                    stall_pc    = 1'b1;
                    stall_ifid  = 1'b1;
                    bubble_idex = 1'b1;
                end
                default: ;
            endcase
            fwd_a     = fwd_a_raw;
            fwd_b     = fwd_b_raw;
            mdu_start = start_ok;
            mdu_busy  = busy;
            mdu_done  = done_q;
        end
    end

endmodule

// File: tb/tb_kim_hazard_ctrl_p.sv
// tb_kim_hazard_ctrl_p: directed and randomized bench for kim_hazard_ctrl_p
// using a timestamp-based reference model of the MDU and hazard rules.
module tb_kim_hazard_ctrl_p;

    localparam int W = 5;
    localparam int L = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] id_rs, id_rt, ex_rt, ex_rd_dst, mem_rd_dst;
    logic         id_mdu_req, id_mdu_read;
    logic         ex_reg_write, ex_mem_read, ex_branch_taken;
    logic         mem_reg_write;
    logic         stall_pc, stall_ifid, bubble_idex, flush_ifid;
    logic [1:0]   fwd_a, fwd_b;
    logic         mdu_start, mdu_busy, mdu_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    kim_hazard_ctrl_p #(
        .REG_ADDR_WIDTH(W),
        .MDU_LATENCY(L),
        .CNT_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .id_rs(id_rs),
        .id_rt(id_rt),
        .id_mdu_req(id_mdu_req),
        .id_mdu_read(id_mdu_read),
        .ex_rt(ex_rt),
        .ex_rd_dst(ex_rd_dst),
        .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken),
        .mem_rd_dst(mem_rd_dst),
        .mem_reg_write(mem_reg_write),
        .stall_pc(stall_pc),
        .stall_ifid(stall_ifid),
        .bubble_idex(bubble_idex),
        .flush_ifid(flush_ifid),
        .fwd_a(fwd_a),
        .fwd_b(fwd_b),
        .mdu_start(mdu_start),
        .mdu_busy(mdu_busy),
        .mdu_done(mdu_done)
    );

    // {stall_pc, stall_ifid, bubble_idex, flush_ifid, start, busy, done}
    wire [6:0] ctl = {stall_pc, stall_ifid, bubble_idex, flush_ifid,
                      mdu_start, mdu_busy, mdu_done};
    wire [3:0] fwd = {fwd_a, fwd_b};

    task automatic clear_in();
        id_rs = '0; id_rt = '0; ex_rt = '0; ex_rd_dst = '0;
        mem_rd_dst = '0; id_mdu_req = 0; id_mdu_read = 0;
        ex_reg_write = 0; ex_mem_read = 0; ex_branch_taken = 0;
        mem_reg_write = 0;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        id_mdu_req = 1; ex_branch_taken = 1; ex_mem_read = 1;
        ex_rt = 5; id_rs = 5; ex_reg_write = 1; ex_rd_dst = 5;
        mem_reg_write = 1; mem_rd_dst = 5;
        @(negedge clk);
        checks += 2;
        if (ctl !== 7'b0)
            begin errors++; $display("FAIL reset_ctl got %b want 0", ctl); end
        if (fwd !== 4'b0)
            begin errors++; $display("FAIL reset_fwd got %b want 0", fwd); end
        advance();
        clear_in();
        rst_n = 1;
        @(negedge clk);
        checks++;
        if (ctl !== 7'b0)
            begin errors++; $display("FAIL post_reset got %b want 0", ctl); end
        advance();
    endtask

    task automatic test_load_use();
        clear_in();
        ex_mem_read = 1; ex_rt = 5; id_rs = 5;
        @(negedge clk);
        checks++;
        if (ctl !== 7'b1110000)
            begin errors++; $display("FAIL lu_stall got %b want 1110000", ctl); end
        advance();
        clear_in();
        id_rs = 5;
        @(negedge clk);
        checks++;
        if (ctl !== 7'b0)
            begin errors++; $display("FAIL lu_release got %b want 0", ctl); end
        advance();
        clear_in();
        ex_mem_read = 1;
        @(negedge clk);
        checks++;
        if (ctl !== 7'b0)
            begin errors++; $display("FAIL lu_r0 got %b want 0", ctl); end
        advance();
    endtask

    task automatic test_branch();
        clear_in();
        ex_branch_taken = 1; ex_mem_read = 1; ex_rt = 7; id_rt = 7;
        id_mdu_req = 1;
        @(negedge clk);
        checks++;
        if (ctl !== 7'b0011000)
            begin errors++; $display("FAIL branch got %b want 0011000", ctl); end
        advance();
    endtask

`ifdef KIM_FWD_EN
    task automatic test_forward();
        clear_in();
        id_rs = 8; id_rt = 8; ex_rd_dst = 8; mem_rd_dst = 8;
        ex_reg_write = 1; mem_reg_write = 1;
        @(negedge clk);
        checks += 2;
        if (fwd !== 4'b1010)
            begin errors++; $display("FAIL fwd_ex got %b want 1010", fwd); end
        if (ctl !== 7'b0)
            begin errors++; $display("FAIL fwd_nostall got %b want 0", ctl); end
        advance();
        ex_reg_write = 0;
        @(negedge clk);
        checks++;
        if (fwd !== 4'b0101)
            begin errors++; $display("FAIL fwd_mem got %b want 0101", fwd); end
        advance();
        ex_reg_write = 1; mem_reg_write = 1; ex_rd_dst = 0; mem_rd_dst = 0;
        id_rs = 0; id_rt = 0;
        @(negedge clk);
        checks++;
        if (fwd !== 4'b0000)
            begin errors++; $display("FAIL fwd_r0 got %b want 0000", fwd); end
        advance();
    endtask
`else
    task automatic test_raw();
        logic [6:0] exp_ctl [3];
        exp_ctl = '{7'b1110000, 7'b1110000, 7'b0000000};
        for (int c = 0; c < 3; c++) begin
            clear_in();
            id_rt = 3;
            if (c == 0) begin ex_reg_write = 1; ex_rd_dst = 3; end
            if (c == 1) begin mem_reg_write = 1; mem_rd_dst = 3; end
            @(negedge clk);
            checks += 2;
            if (ctl !== exp_ctl[c]) begin
                errors++;
                $display("FAIL raw_c%0d got %b want %b", c, ctl, exp_ctl[c]);
            end
            if (fwd !== 4'b0)
                begin errors++; $display("FAIL raw_fwd_c%0d got %b want 0", c, fwd); end
            advance();
        end
    endtask
`endif

    task automatic test_mdu();
        logic [6:0] exp_ctl [7];
        exp_ctl = '{7'b0000100, 7'b0000010, 7'b1110010, 7'b1110010,
                    7'b1110010, 7'b0000001, 7'b0000000};
        for (int c = 0; c < 7; c++) begin
            clear_in();
            id_mdu_req  = (c == 0);
            id_mdu_read = (c >= 2 && c <= 5);
            @(negedge clk);
            checks++;
            if (ctl !== exp_ctl[c]) begin
                errors++;
                $display("FAIL mdu_c%0d got %b want %b", c, ctl, exp_ctl[c]);
            end
            advance();
        end
    endtask

    task automatic test_reset_mid_mdu();
        logic [6:0] exp_ctl [7];
        for (int c = 0; c < 7; c++) begin
            clear_in();
            id_mdu_req = (c == 0);
            rst_n = (c != 2);
            @(negedge clk);
            checks++;
            if (ctl !== ((c == 0) ? 7'b0000100 : (c == 1) ? 7'b0000010 : 7'b0)) begin
                errors++;
                $display("FAIL rstmid_c%0d got %b", c, ctl);
            end
            advance();
        end
        exp_ctl = '{7'b0000100, 7'b0000010, 7'b0000010, 7'b0000010,
                    7'b0000010, 7'b0000001, 7'b0000000};
        for (int c = 0; c < 7; c++) begin
            clear_in();
            id_mdu_req = (c == 0);
            @(negedge clk);
            checks++;
            if (ctl !== exp_ctl[c]) begin
                errors++;
                $display("FAIL restart_c%0d got %b want %b", c, ctl, exp_ctl[c]);
            end
            advance();
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [W-1:0] s);
        if (ex_reg_write && ex_rd_dst != 0 && ex_rd_dst == s) return 2'b10;
        if (mem_reg_write && mem_rd_dst != 0 && mem_rd_dst == s) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit ref_dep(input logic [W-1:0] s);
        return s != 0 && ((ex_reg_write && ex_rd_dst == s) ||
                          (mem_reg_write && mem_rd_dst == s));
    endfunction

    // Model: the MDU is busy for the L cycles after the start cycle and
    // signals done in the cycle after that.
    task automatic test_random();
        int  cyc = 0;
        int  st = 0;
        bit  started = 0;
        bit  m_busy, m_done, lu, mh, raw, stall, start;
        logic [6:0] e_ctl;
        logic [3:0] e_fwd;
        for (int i = 0; i < 2000; i++) begin
            rst_n = (i == 0) ? 1'b0 : ($urandom_range(0, 39) != 0);
            id_rs = W'($urandom_range(0, 3));
            id_rt = W'($urandom_range(0, 3));
            ex_rt = W'($urandom_range(0, 3));
            ex_rd_dst = W'($urandom_range(0, 3));
            mem_rd_dst = W'($urandom_range(0, 3));
            id_mdu_req = ($urandom_range(0, 5) == 0);
            id_mdu_read = ($urandom_range(0, 3) == 0);
            ex_reg_write = $urandom_range(0, 1) != 0;
            mem_reg_write = $urandom_range(0, 1) != 0;
            ex_mem_read = ($urandom_range(0, 3) == 0);
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            m_busy = started && cyc > st && cyc <= st + L;
            m_done = started && cyc == st + L + 1;
            lu = ex_mem_read && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt);
            mh = m_busy && (id_mdu_read || id_mdu_req);
`ifdef KIM_FWD_EN
            raw = 0;
            e_fwd = {ref_fwd(id_rs), ref_fwd(id_rt)};
`else
            raw = ref_dep(id_rs) || ref_dep(id_rt);
            e_fwd = 4'b0;
`endif
            stall = lu || mh || raw;
            start = !m_busy && id_mdu_req && !stall && !ex_branch_taken;
            e_ctl = {!ex_branch_taken && stall, !ex_branch_taken && stall,
                     ex_branch_taken || stall, ex_branch_taken,
                     start, m_busy, m_done};
            if (!rst_n) begin e_ctl = 0; e_fwd = 0; end
            checks += 2;
            if (ctl !== e_ctl) begin
                errors++;
                $display("FAIL rand_ctl cyc%0d got %b want %b", cyc, ctl, e_ctl);
            end
            if (fwd !== e_fwd) begin
                errors++;
                $display("FAIL rand_fwd cyc%0d got %b want %b", cyc, fwd, e_fwd);
            end
            if (!rst_n) started = 0;
            else if (start) begin started = 1; st = cyc; end
            advance();
            cyc++;
        end
        rst_n = 1;
    endtask

    initial begin
        clear_in();
        rst_n = 0;
        advance();
        test_reset();
        test_load_use();
        test_branch();
`ifdef KIM_FWD_EN
        test_forward();
`else
        test_raw();
`endif
        test_mdu();
        test_reset_mid_mdu();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
